adder_operand_sequencer: RTL and testbench
==========================================

Name: adder_operand_sequencer

Overview:
Upstream stage that produces the packed 8-bit operand word {A[3:0], B[3:0]} consumed by the nibble adder's ui_in. It has two modes:
- LOAD: the host supplies A then B as nibbles over a valid/ready handshake.
- SWEEP: the block autonomously steps through all 2^(2*OPW) operand combinations, holding each one for a programmable number of cycles.

Every new word is flagged with a one-cycle word_valid strobe.

Parameters:
- OPW, 4, operand width in bits; operand_word is 2*OPW bits wide with A in the upper half.
- HOLD_W, 4, width of the hold_cycles input and of the internal hold counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ena  input  1  global enable; when low, all state, counters and registers freeze.
- mode  input  1  sampled on start; 0 = LOAD, 1 = SWEEP.
- start  input  1  begin operation; honoured only in IDLE.
- stop  input  1  return to IDLE; see Behaviour.
- hold_cycles  input  HOLD_W  SWEEP dwell; each word is held hold_cycles+1 cycles; sampled on start.
- in_valid  input  1  host nibble valid.
- in_data  input  OPW  host nibble.
- in_ready  output  1  block accepts in_data this cycle.
- operand_word  output  2*OPW  registered {A,B} driven to the adder.
- word_valid  output  1  one-cycle pulse when operand_word takes a new value.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at normal SWEEP completion.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, operand_word=0, A/B capture registers=0, idx=0, hold counter=0. Outputs word_valid, done, in_ready and busy are all 0.
- ena=0: no state or register changes; word_valid, done and in_ready are forced 0; operand_word holds its value.
- States: IDLE, GET_A, GET_B, SWEEP.
- IDLE:
  - start=1 with mode=0 -> GET_A.
  - start=1 with mode=1 -> SWEEP; idx=0 and hold_cycles is latched.
  - start while not in IDLE is ignored.
- GET_A: in_ready=1. A handshake (in_valid & in_ready) captures A -> GET_B. stop=1 -> IDLE; stop wins over a simultaneous handshake.
- GET_B: in_ready=1.
  - A handshake captures B. On the next edge operand_word={A,B}, word_valid=1 for exactly 1 cycle, state -> GET_A. LOAD is continuous.
  - stop in GET_B -> IDLE; the partial A is discarded and operand_word is unchanged.
- Latency: the word appears on the clock edge after the B handshake (1 cycle). in_ready is registered-state based: high in GET_A/GET_B, not dependent on in_valid.
- SWEEP:
  - On entry: operand_word=0, word_valid=1 in the first SWEEP cycle.
  - Each word is held for H+1 cycles (H = latched hold_cycles), then operand_word=idx+1 with a word_valid pulse.
  - After the all-ones word (2^(2*OPW)-1) has been held H+1 cycles: done=1 for 1 cycle, state -> IDLE. operand_word retains all-ones and idx does not wrap to 0.
  - Total length from the first word_valid to done is 2^(2*OPW)*(H+1) cycles.
- stop in SWEEP -> IDLE on the next edge, with no done and no further word_valid. operand_word keeps its current value.
- hold_cycles changes while busy have no effect.
- ena low during SWEEP stretches the current hold; the count resumes where it left off.
- Reset mid-operation returns everything to reset values immediately, with no done pulse.

Test Plan:
- Reset: assert rst mid-SWEEP at idx=0x42 -> outputs go to 0 and state goes to IDLE asynchronously, before the next clk edge; after release, busy=0 and word_valid=0.
- LOAD: start with mode=0; send 3 then 5 with in_valid held high -> operand_word=0x35 one cycle after the second handshake, word_valid high 1 cycle, in_ready stays 1. A further pair 0xC, 0x3 -> 0xC3.
- SWEEP, H=0: start with mode=1 -> word_valid high for 256 consecutive cycles carrying 0x00..0xFF. done pulses the cycle after 0xFF's single hold cycle, then busy=0 and operand_word=0xFF.
- SWEEP, H=2: each value is held 3 cycles and word_valid pulses every 3rd cycle. Check that 0x81, 0xC3 and 0xE7 appear. done fires 768 cycles after the first word_valid.
- ena/stop: hold ena=0 in GET_B with in_valid=1 -> no capture and in_ready=0; raising ena then captures. stop asserted at idx=0x10 in SWEEP -> IDLE with no done and operand_word=0x10.
- Start while busy: pulse start with mode=0 during SWEEP -> the sweep continues unaffected and completes with done.

Source files
------------

// File: rtl/adder_operand_sequencer_if.sv
// adder_operand_sequencer_if
//   Host-side bundle for the operand sequencer: mode/start/stop control, the
//   hold_cycles dwell setting, the nibble valid/ready input and the operand
//   word output with its status strobes.
//   slave  : the sequencer's view (controls and nibbles in, word and status out)
//   master : the host's view
interface adder_operand_sequencer_if #(
    parameter int OPW    = 4,
    parameter int HOLD_W = 4
);
    logic                mode;
    logic                start;
    logic                stop;
    logic [HOLD_W-1:0]   hold_cycles;
    logic                in_valid;
    logic [OPW-1:0]      in_data;
    logic                in_ready;
    logic [2*OPW-1:0]    operand_word;
    logic                word_valid;
    logic                busy;
    logic                done;

    modport slave (
        input  mode, start, stop, hold_cycles, in_valid, in_data,
        output in_ready, operand_word, word_valid, busy, done
    );

    modport master (
        output mode, start, stop, hold_cycles, in_valid, in_data,
        input  in_ready, operand_word, word_valid, busy, done
    );
endinterface

// File: rtl/adder_operand_sequencer.sv
// adder_operand_sequencer
//   Produces the packed operand word {A,B} for the nibble adder.
//   LOAD  : host sends A then B over in_valid/in_ready; every B completes a
//           word, which appears on the edge that accepts B.
//   SWEEP : steps operand_word through 0 .. 2^(2*OPW)-1, each value held
//           hold_cycles+1 enabled cycles, then pulses done.
//   Ports:
//     clk    rising-edge clock
//     rst    asynchronous active-high reset
//     ena    global enable; low freezes every register and masks strobes
//     bus    adder_operand_sequencer_if.slave (mode, start, stop,
//            hold_cycles, in_valid, in_data / in_ready, operand_word,
//            word_valid, busy, done)
module adder_operand_sequencer #(
    parameter int OPW    = 4,
    parameter int HOLD_W = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    adder_operand_sequencer_if.slave    bus
);
    localparam int WW = 2 * OPW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GET_A = 2'd1,
        GET_B = 2'd2,
        SWEEP = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [OPW-1:0]     a_q, a_d;
    // B is never needed on its own: it lands directly in the low half of
    // word_q, which acts as the B capture register.
    logic [WW-1:0]      word_q, word_d;
    logic [WW-1:0]      idx_q, idx_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [HOLD_W-1:0]  hlat_q, hlat_d;
    logic               wv_q, wv_d;
    logic               done_q, done_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        word_d  = word_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        hlat_d  = hlat_q;
        wv_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.mode) begin
                        state_d = SWEEP;
                        idx_d   = '0;
                        hold_d  = '0;
                        hlat_d  = bus.hold_cycles;
                        word_d  = '0;
                        wv_d    = 1'b1;
                    end else begin
                        state_d = GET_A;
                    end
                end
            end
            GET_A: begin
                // stop has priority over a handshake in the same cycle
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.in_valid) begin
                    a_d     = bus.in_data;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.in_valid) begin
                    word_d  = {a_q, bus.in_data};
                    wv_d    = 1'b1;
                    state_d = GET_A;
                end
            end
            SWEEP: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (hold_q == hlat_q) begin
                    if (idx_q == {WW{1'b1}}) begin
                        // last word fully held: finish without wrapping idx
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        word_d = idx_q + 1'b1;
                        wv_d   = 1'b1;
                        hold_d = '0;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            word_q <= '0;
            idx_q  <= '0;
            hold_q <= '0;
            hlat_q <= '0;
            wv_q   <= 1'b0;
            done_q <= 1'b0;
        end else if (ena) begin
            a_q    <= a_d;
            word_q <= word_d;
            idx_q  <= idx_d;
            hold_q <= hold_d;
            hlat_q <= hlat_d;
            wv_q   <= wv_d;
            done_q <= done_d;
        end else begin
            // Strobes are masked while disabled; dropping them here keeps a
            // word from being flagged twice when ena comes back.
            wv_q   <= 1'b0;
            done_q <= 1'b0;
        end
    end

    assign bus.in_ready     = ena && (state_q == GET_A || state_q == GET_B);
    assign bus.operand_word = word_q;
    assign bus.word_valid   = ena && wv_q;
    assign bus.done         = ena && done_q;
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_adder_operand_sequencer.sv
module tb_adder_operand_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    adder_operand_sequencer_if #(.OPW(4), .HOLD_W(4)) bus ();

    adder_operand_sequencer #(.OPW(4), .HOLD_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        int seen;
        bus.mode = 0; bus.start = 0; bus.stop = 0; bus.hold_cycles = 0;
        bus.in_valid = 0; bus.in_data = 0;

        // reset state
        cyc(); cyc();
        chk("rst_word", 32'(bus.operand_word), 32'h00);
        chk("rst_wv", 32'(bus.word_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_rdy", 32'(bus.in_ready), 0);
        chk("rst_done", 32'(bus.done), 0);
        rst = 0;
        cyc();

        // LOAD: 3,5 -> 0x35 ; C,3 -> 0xC3
        bus.mode = 0; bus.start = 1; cyc(); bus.start = 0;
        chk("ld_rdy_a", 32'(bus.in_ready), 1);
        chk("ld_busy", 32'(bus.busy), 1);
        bus.in_valid = 1; bus.in_data = 4'h3; cyc();
        chk("ld_wv_a", 32'(bus.word_valid), 0);
        chk("ld_rdy_b", 32'(bus.in_ready), 1);
        bus.in_data = 4'h5; cyc();
        chk("ld_w35", 32'(bus.operand_word), 32'h35);
        chk("ld_wv35", 32'(bus.word_valid), 1);
        chk("ld_rdy35", 32'(bus.in_ready), 1);
        bus.in_data = 4'hC; cyc();
        chk("ld_wv_c", 32'(bus.word_valid), 0);
        bus.in_data = 4'h3; cyc();
        chk("ld_wC3", 32'(bus.operand_word), 32'hC3);
        chk("ld_wvC3", 32'(bus.word_valid), 1);
        bus.in_valid = 0; cyc();
        chk("ld_wv_off", 32'(bus.word_valid), 0);
        chk("ld_hold", 32'(bus.operand_word), 32'hC3);

        // ena low in GET_B blocks capture
        bus.in_valid = 1; bus.in_data = 4'h7; cyc();
        ena = 0; bus.in_data = 4'h9; #1;
        chk("ena_rdy0", 32'(bus.in_ready), 0);
        cyc(); cyc();
        chk("ena_word", 32'(bus.operand_word), 32'hC3);
        chk("ena_wv", 32'(bus.word_valid), 0);
        chk("ena_busy", 32'(bus.busy), 1);
        ena = 1; #1;
        chk("ena_rdy1", 32'(bus.in_ready), 1);
        cyc();
        chk("ena_w79", 32'(bus.operand_word), 32'h79);
        chk("ena_wv79", 32'(bus.word_valid), 1);

        // stop in GET_B discards partial A, word unchanged
        bus.in_data = 4'h2; cyc();
        bus.in_data = 4'h4; bus.stop = 1; cyc();
        bus.stop = 0; bus.in_valid = 0;
        chk("stopb_busy", 32'(bus.busy), 0);
        chk("stopb_word", 32'(bus.operand_word), 32'h79);
        chk("stopb_wv", 32'(bus.word_valid), 0);

        // stop in GET_A beats a simultaneous handshake
        bus.start = 1; cyc(); bus.start = 0;
        bus.in_valid = 1; bus.in_data = 4'h1; bus.stop = 1; cyc();
        bus.in_valid = 0; bus.stop = 0;
        chk("stopa_busy", 32'(bus.busy), 0);
        cyc();
        chk("stopa_word", 32'(bus.operand_word), 32'h79);

        // SWEEP H=0, with a start pulse while busy and a hold_cycles change
        bus.mode = 1; bus.hold_cycles = 0; bus.start = 1; cyc();
        bus.start = 0; bus.hold_cycles = 4'd5;
        for (int i = 0; i < 256; i++) begin
            chk("sw0_word", 32'(bus.operand_word), 32'(i));
            chk("sw0_wv", 32'(bus.word_valid), 1);
            chk("sw0_done", 32'(bus.done), 0);
            if (i == 100) begin bus.mode = 0; bus.start = 1; end
            if (i == 101) begin bus.start = 0; bus.mode = 1; end
            cyc();
        end
        chk("sw0_donepulse", 32'(bus.done), 1);
        chk("sw0_idle", 32'(bus.busy), 0);
        chk("sw0_last", 32'(bus.operand_word), 32'hFF);
        chk("sw0_wv_end", 32'(bus.word_valid), 0);
        cyc();
        chk("sw0_done1cyc", 32'(bus.done), 0);

        // SWEEP H=2
        bus.hold_cycles = 4'd2; bus.start = 1; cyc(); bus.start = 0;
        seen = 0;
        for (int c = 0; c < 768; c++) begin
            chk("sw2_wv", 32'(bus.word_valid), (c % 3 == 0) ? 1 : 0);
            chk("sw2_word", 32'(bus.operand_word), 32'(c / 3));
            chk("sw2_done", 32'(bus.done), 0);
            if (c % 3 == 0 && bus.word_valid &&
                (bus.operand_word == 8'h81 || bus.operand_word == 8'hC3 ||
                 bus.operand_word == 8'hE7))
                seen++;
            cyc();
        end
        chk("sw2_seen", 32'(seen), 3);
        chk("sw2_done768", 32'(bus.done), 1);
        chk("sw2_idle", 32'(bus.busy), 0);
        chk("sw2_last", 32'(bus.operand_word), 32'hFF);

        // SWEEP H=0: ena stretch at 0x05, then stop at 0x10
        bus.hold_cycles = 4'd0; bus.start = 1; cyc(); bus.start = 0;
        for (int i = 0; i < 5; i++) cyc();
        chk("str_w5", 32'(bus.operand_word), 32'h05);
        chk("str_wv5", 32'(bus.word_valid), 1);
        ena = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("str_frz", 32'(bus.operand_word), 32'h05);
            chk("str_wv0", 32'(bus.word_valid), 0);
        end
        ena = 1; cyc();
        chk("str_w6", 32'(bus.operand_word), 32'h06);
        chk("str_wv6", 32'(bus.word_valid), 1);
        repeat (10) cyc();
        chk("stp_w10", 32'(bus.operand_word), 32'h10);
        bus.stop = 1; cyc(); bus.stop = 0;
        chk("stp_busy", 32'(bus.busy), 0);
        chk("stp_word", 32'(bus.operand_word), 32'h10);
        chk("stp_done", 32'(bus.done), 0);
        chk("stp_wv", 32'(bus.word_valid), 0);
        cyc();
        chk("stp_done2", 32'(bus.done), 0);
        chk("stp_word2", 32'(bus.operand_word), 32'h10);

        // asynchronous reset mid-sweep at 0x42
        bus.start = 1; cyc(); bus.start = 0;
        repeat (8'h42) cyc();
        chk("ar_w42", 32'(bus.operand_word), 32'h42);
        #2 rst = 1;
        #1;
        chk("ar_word", 32'(bus.operand_word), 32'h00);
        chk("ar_busy", 32'(bus.busy), 0);
        chk("ar_wv", 32'(bus.word_valid), 0);
        chk("ar_done", 32'(bus.done), 0);
        cyc(); rst = 0; cyc();
        chk("ar_post_busy", 32'(bus.busy), 0);
        chk("ar_post_wv", 32'(bus.word_valid), 0);
        chk("ar_post_word", 32'(bus.operand_word), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
